clk_div: RTL and testbench

Clock-generation block for the CPU top level. It runs a 32-bit free-running divider counter from the board clock. From that counter it derives a registered CPU clock, `Clk_CPU`, whose rate is chosen by switch `SW2`: fast for normal running, slow for single-step and visual debugging. It also keeps an 11-bit count of CPU clock rising edges for display logic.

---
 rtl/clk_pkg.sv | 6 +
 rtl/sync2.sv | 20 ++
 rtl/clk_div.sv | 53 +++++
 tb/tb_clk_div.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/clk_pkg.sv
// Shared clock-generation constants: default divider taps and edge-counter width.
package clk_pkg;
  localparam int FAST_BIT_DEF = 2;
  localparam int SLOW_BIT_DEF = 24;
  localparam int NUM_W_DEF    = 11;
endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for a single asynchronous control input.
module sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);
  logic meta;

  // Shift the async input through two flops; the second flop is safe to use.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end
endmodule

// File: rtl/clk_div.sv
// Free-running divider plus a registered CPU clock tapped from it.
// The speed select only changes while both candidate taps are low, so a
// speed change can never produce a runt pulse. num counts CPU clock rises.
module clk_div
  import clk_pkg::*;
#(
  parameter int FAST_BIT = FAST_BIT_DEF,
  parameter int SLOW_BIT = SLOW_BIT_DEF,
  parameter int NUM_W    = NUM_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             SW2,
  output logic [31:0]      clkdiv,
  output logic             Clk_CPU,
  output logic [NUM_W-1:0] num
);
  logic sw_s;
  logic sel;
  logic clk_nxt;
  logic sel_ok;

  sync2 u_sync_sw2 (
    .clk   (clk),
    .rst_n (rst),
    .d     (SW2),
    .q     (sw_s)
  );

  // Next CPU clock level and the "both taps low" window for reselection.
  always_comb begin
    clk_nxt = sel ? clkdiv[SLOW_BIT] : clkdiv[FAST_BIT];
    sel_ok  = !clkdiv[FAST_BIT] && !clkdiv[SLOW_BIT];
  end

  // Divider, select, CPU clock and rising-edge counter; all use pre-edge
  // values, so an edge coinciding with a speed change uses the old select.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      clkdiv  <= '0;
      sel     <= 1'b0;
      Clk_CPU <= 1'b0;
      num     <= '0;
    end else begin
      clkdiv  <= clkdiv + 32'd1;
      if (sel_ok)
        sel <= sw_s;
      Clk_CPU <= clk_nxt;
      if (!Clk_CPU && clk_nxt)
        num <= num + {{(NUM_W-1){1'b0}}, 1'b1};
    end
  end
endmodule

// File: tb/tb_clk_div.sv
// Directed bench for clk_div with a cycle scoreboard and spec-derived checks.
module tb_clk_div;
  localparam int FB = 2;
  localparam int SB = 6;
  localparam int NW = 11;

  typedef struct packed {
    logic [31:0]   div;
    logic          cpu;
    logic [NW-1:0] num;
  } obs_t;

  logic          clk, rst, SW2;
  logic [31:0]   clkdiv;
  logic          Clk_CPU;
  logic [NW-1:0] num;

  clk_div #(.FAST_BIT(FB), .SLOW_BIT(SB), .NUM_W(NW)) dut (
    .clk     (clk),
    .rst     (rst),
    .SW2     (SW2),
    .clkdiv  (clkdiv),
    .Clk_CPU (Clk_CPU),
    .num     (num)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;
  obs_t exp_q[$];

  // reference state
  logic [31:0]   m_div;
  logic          m_s1, m_s2, m_sel, m_cpu;
  logic [NW-1:0] m_num;

  // pulse-width tracking
  int hi_run, min_hi;
  logic tracking;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    m_div = '0; m_s1 = 0; m_s2 = 0; m_sel = 0; m_cpu = 0; m_num = '0;
    exp_q.delete();
  endtask

  // One clk cycle: advance model at the edge, push expectation, compare at negedge.
  task automatic tick();
    logic nxt;
    obs_t e;
    @(posedge clk);
    if (rst) begin
      nxt = m_sel ? m_div[SB] : m_div[FB];
      if (!m_cpu && nxt) m_num = m_num + 1'b1;
      if (!m_div[FB] && !m_div[SB]) m_sel = m_s2;
      m_cpu = nxt;
      m_div = m_div + 32'd1;
      m_s2  = m_s1;
      m_s1  = SW2;
    end
    exp_q.push_back({m_div, m_cpu, m_num});
    @(negedge clk);
    e = exp_q.pop_front();
    chk("sb_clkdiv", clkdiv, e.div);
    chk("sb_cpu", {31'd0, Clk_CPU}, {31'd0, e.cpu});
    chk("sb_num", {21'd0, num}, {21'd0, e.num});
    if (tracking) begin
      if (Clk_CPU) hi_run++;
      else begin
        if (hi_run > 0 && hi_run < min_hi) min_hi = hi_run;
        hi_run = 0;
      end
    end
  endtask

  // Assert reset between edges and confirm the clear is immediate.
  task automatic async_rst();
    #1 rst = 1'b0;
    #1;
    model_clear();
    chk("arst_clkdiv", clkdiv, 32'd0);
    chk("arst_cpu", {31'd0, Clk_CPU}, 32'd0);
    chk("arst_num", {21'd0, num}, 32'd0);
  endtask

  initial begin
    rst = 1'b0; SW2 = 1'b0;
    tracking = 1'b0; hi_run = 0; min_hi = 1 << 30;
    model_clear();

    // reset held with clock running
    for (int i = 0; i < 40; i++) begin
      tick();
      chk("rst_hold_div", clkdiv, 32'd0);
    end

    // fast mode from release
    rst = 1'b1;
    for (int k = 1; k <= 21; k++) begin
      tick();
      chk("fast_cpu", {31'd0, Clk_CPU}, (32'(k - 1) >> FB) & 32'd1);
      if (k == 20) chk("div_20", clkdiv, 32'd20);
      if (k == 5)  chk("num_e5", {21'd0, num}, 32'd1);
      if (k == 13) chk("num_e13", {21'd0, num}, 32'd2);
      if (k == 21) chk("num_e21", {21'd0, num}, 32'd3);
    end

    // mid-run reset at clkdiv=7
    async_rst();
    @(negedge clk);
    rst = 1'b1;
    for (int k = 1; k <= 7; k++) tick();
    chk("pre_arst_div", clkdiv, 32'd7);
    async_rst();
    for (int i = 0; i < 3; i++) tick();
    @(negedge clk);
    rst = 1'b1;
    tick();
    chk("restart_div", clkdiv, 32'd1);

    // speed change to slow at clkdiv=100
    for (int k = 2; k <= 100; k++) tick();
    chk("div_100", clkdiv, 32'd100);
    SW2 = 1'b1;
    tracking = 1'b1; hi_run = 0; min_hi = 1 << 30;
    for (int k = 101; k <= 330; k++) begin
      tick();
      if (k == 128) chk("last_fast_hi", {31'd0, Clk_CPU}, 32'd1);
      if (k >= 129 && k <= 192) chk("slow_low", {31'd0, Clk_CPU}, 32'd0);
      if (k == 193) chk("slow_rise", {31'd0, Clk_CPU}, 32'd1);
      if (k == 256) chk("slow_hi_end", {31'd0, Clk_CPU}, 32'd1);
      if (k == 257) chk("slow_fall", {31'd0, Clk_CPU}, 32'd0);
    end
    tracking = 1'b0;
    chk("min_hi_ge4", (min_hi >= 4) ? 32'd1 : 32'd0, 32'd1);
    chk("slow_hi_len", 32'(min_hi), 32'd4);
    SW2 = 1'b0;

    // num wrap after 2048 rises in fast mode
    async_rst();
    @(negedge clk);
    rst = 1'b1;
    for (int k = 1; k <= 16380; k++) tick();
    chk("num_max", {21'd0, num}, 32'd2047);
    chk("pre_wrap_cpu", {31'd0, Clk_CPU}, 32'd0);
    tick();
    chk("num_wrap", {21'd0, num}, 32'd0);
    chk("wrap_cpu_rise", {31'd0, Clk_CPU}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
